// File: rtl/stream_demux4.sv
// Four-way stream demultiplexer: one input stream steered by in_sel into four
// independent one-entry output slots, each with a delivered-beat counter.
//
// Per-slot state table:
//   state | meaning
//   EMPTY | slot holds no beat, out_valid[k]=0, can always accept
//   FULL  | slot holds a beat on outk_data, out_valid[k]=1
module stream_demux4 #(
   parameter int DWIDTH = 32,
   parameter int CWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] in_data,
   input  logic [1:0]        in_sel,
   output logic [3:0]        out_valid,
   input  logic [3:0]        out_ready,
   output logic [DWIDTH-1:0] out0_data,
   output logic [DWIDTH-1:0] out1_data,
   output logic [DWIDTH-1:0] out2_data,
   output logic [DWIDTH-1:0] out3_data,
   output logic [CWIDTH-1:0] cnt0,
   output logic [CWIDTH-1:0] cnt1,
   output logic [CWIDTH-1:0] cnt2,
   output logic [CWIDTH-1:0] cnt3,
   output logic              busy
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_e;

   slot_e             slot_q [4];
   slot_e             slot_d [4];
   logic [DWIDTH-1:0] data_q [4];
   logic [DWIDTH-1:0] data_d [4];
   logic [CWIDTH-1:0] cnt_q  [4];
   logic [CWIDTH-1:0] cnt_d  [4];
   logic              accept;

   // A full slot can still take a beat in the same cycle its sink drains it.
   assign in_ready = !rst && ((slot_q[in_sel] == EMPTY) || out_ready[in_sel]);
   assign accept   = in_valid && in_ready;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         slot_d[k] = slot_q[k];
         data_d[k] = data_q[k];
         cnt_d[k]  = cnt_q[k];
         if ((slot_q[k] == FULL) && out_ready[k]) begin
            slot_d[k] = EMPTY;
            cnt_d[k]  = cnt_q[k] + CWIDTH'(1);
         end
         if (accept && (in_sel == 2'(k))) begin
            slot_d[k] = FULL;
            data_d[k] = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            slot_q[k] <= EMPTY;
            data_q[k] <= '0;
            cnt_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            slot_q[k] <= slot_d[k];
            data_q[k] <= data_d[k];
            cnt_q[k]  <= cnt_d[k];
         end
      end
   end

   always_comb begin
      out_valid = '0;
      for (int k = 0; k < 4; k++) begin
         out_valid[k] = (slot_q[k] == FULL);
      end
   end

   assign busy      = |out_valid;
   assign out0_data = data_q[0];
   assign out1_data = data_q[1];
   assign out2_data = data_q[2];
   assign out3_data = data_q[3];
   assign cnt0      = cnt_q[0];
   assign cnt1      = cnt_q[1];
   assign cnt2      = cnt_q[2];
   assign cnt3      = cnt_q[3];

endmodule

// File: tb/tb_stream_demux4.sv
// Scoreboard bench for stream_demux4: per-port FIFOs of expected beats plus
// modelled delivery counters, checked by a negedge monitor.
module tb_stream_demux4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [1:0]  in_sel = '0;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready = '0;
   logic [31:0] out0_data, out1_data, out2_data, out3_data;
   logic [7:0]  cnt0, cnt1, cnt2, cnt3;
   logic        busy;

   stream_demux4 #(.DWIDTH(32), .CWIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .out_valid(out_valid), .out_ready(out_ready),
      .out0_data(out0_data), .out1_data(out1_data),
      .out2_data(out2_data), .out3_data(out3_data),
      .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
      .busy(busy)
   );

   always #5 clk = ~clk;

   logic [31:0] expq [4][$];
   logic [7:0]  cnt_m [4];
   int          nvec = 0;
   int          nerr = 0;
   bit          mon_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      nvec++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   function automatic logic [31:0] dout(input int k);
      case (k)
         0:       return out0_data;
         1:       return out1_data;
         2:       return out2_data;
         default: return out3_data;
      endcase
   endfunction

   function automatic logic [7:0] dcnt(input int k);
      case (k)
         0:       return cnt0;
         1:       return cnt1;
         2:       return cnt2;
         default: return cnt3;
      endcase
   endfunction

   // Monitor: a beat is at the head of its port queue exactly while the slot is full.
   always @(negedge clk) begin
      if (mon_en) begin
         logic exp_rdy;
         exp_rdy = !rst && ((expq[in_sel].size() == 0) || out_ready[in_sel]);
         chk("in_ready", in_ready, exp_rdy);
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid[%0d]", k), out_valid[k], expq[k].size() != 0);
            if (expq[k].size() != 0) chk($sformatf("out%0d_data", k), dout(k), expq[k][0]);
            chk($sformatf("cnt%0d", k), dcnt(k), cnt_m[k]);
         end
         chk("busy", busy, (expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()) != 0);
         if (!rst) begin
            for (int k = 0; k < 4; k++) begin
               if (out_valid[k] && out_ready[k]) begin
                  if (expq[k].size() != 0) void'(expq[k].pop_front());
                  cnt_m[k] = cnt_m[k] + 8'd1;
               end
            end
         end
      end
   end

   // Drive one cycle; returns at posedge+1 with the model updated for that edge.
   task automatic step(input logic r, input logic iv, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] ordy);
      logic acc;
      rst = r; in_valid = iv; in_sel = s; in_data = d; out_ready = ordy;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (r) begin
         for (int k = 0; k < 4; k++) begin
            expq[k].delete();
            cnt_m[k] = 8'd0;
         end
      end else if (acc) begin
         expq[s].push_back(d);
      end
      #1;
   endtask

   task automatic chk_reset_state();
      chk("rst out_valid", out_valid, 4'b0000);
      chk("rst busy", busy, 1'b0);
      chk("rst cnt", {cnt0, cnt1, cnt2, cnt3}, 32'h0);
      chk("rst data0", out0_data, 32'h0);
      chk("rst data1", out1_data, 32'h0);
      chk("rst data2", out2_data, 32'h0);
      chk("rst data3", out3_data, 32'h0);
   endtask

   initial begin
      logic [7:0] c0_exp;
      for (int k = 0; k < 4; k++) cnt_m[k] = 8'd0;
      @(posedge clk); #1;
      step(1, 0, 0, 0, 4'h0);
      mon_en = 1'b1;
      step(1, 1, 0, 32'h1234, 4'hF);
      chk_reset_state();

      // single beat to port 2
      step(0, 1, 2, 32'hDEADBEEF, 4'hF);
      chk("d31 out_valid", out_valid, 4'b0100);
      chk("d31 out2_data", out2_data, 32'hDEADBEEF);
      step(0, 0, 0, 0, 4'hF);
      chk("d31 cnt2", cnt2, 8'd1);
      chk("d31 out_valid idle", out_valid, 4'b0000);

      // backpressure on port 1
      step(0, 1, 1, 32'h11, 4'b0000);
      chk("d32 out1_data", out1_data, 32'h11);
      step(0, 1, 1, 32'h22, 4'b0000);
      chk("d32 in_ready stalled", in_ready, 1'b0);
      chk("d32 out1 hold", out1_data, 32'h11);
      step(0, 1, 1, 32'h22, 4'b0010);
      chk("d32 cnt1 first", cnt1, 8'd1);
      chk("d32 out1 replaced", out1_data, 32'h22);
      chk("d32 out_valid", out_valid, 4'b0010);
      step(0, 0, 0, 0, 4'b0010);
      chk("d32 cnt1 second", cnt1, 8'd2);

      // port 0 stalled full while port 3 streams
      step(0, 1, 0, 32'hA0, 4'b0000);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 3, 32'h300 + i, 4'b1000);
         chk("d33 out3_data", out3_data, 32'h300 + i);
         chk("d33 out0 held", out0_data, 32'hA0);
         chk("d33 out_valid", out_valid, 4'b1001);
      end
      step(0, 0, 0, 0, 4'b1001);

      // counter wrap on port 0
      c0_exp = cnt_m[0] + 8'd1;
      for (int i = 0; i < 257; i++) step(0, 1, 0, 32'h5000 + i, 4'b0001);
      step(0, 0, 0, 0, 4'b0001);
      chk("d34 cnt0 wrap", cnt0, c0_exp);

      // reset with all slots full
      for (int k = 0; k < 4; k++) step(0, 1, 2'(k), 32'hF0 + k, 4'b0000);
      chk("d35 all full", out_valid, 4'b1111);
      step(1, 1, 0, 32'h77, 4'b0000);
      chk_reset_state();
      step(0, 1, 1, 32'h55, 4'hF);
      chk("d35 post out_valid", out_valid, 4'b0010);
      chk("d35 post out1_data", out1_data, 32'h55);
      step(0, 0, 0, 0, 4'hF);

      // randomized traffic; monitor checks order, loss and hold-under-stall
      for (int i = 0; i < 10000; i++) begin
         logic [3:0] ordy;
         for (int k = 0; k < 4; k++) ordy[k] = ($urandom_range(0, 99) < 55);
         step(($urandom_range(0, 999) == 0), ($urandom_range(0, 99) < 70),
              2'($urandom_range(0, 3)), $urandom, ordy);
      end
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 4'hF);
      chk("final drained", out_valid, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stream_demux4.md
STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 SHALL have parameter: DWIDTH, 32, payload width in bits.
REQ-002 SHALL have parameter: CWIDTH, 8, width of each per-output beat counter.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-004 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  source beat valid.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 in_data  input  DWIDTH  source payload.
REQ-009 in_sel  input  2  destination index 0..3; qualified by in_valid.
REQ-010 out_valid  output  4  bit k: output slot k holds a beat.
REQ-011 out_ready  input  4  bit k: sink k consumes beat this cycle.
REQ-012 out0_data, out1_data, out2_data, out3_data  output  DWIDTH each  registered payload of slot k.
REQ-013 cnt0, cnt1, cnt2, cnt3  output  CWIDTH each  beats delivered to sink k.
REQ-014 busy  output  1  OR of out_valid.

Function
REQ-015 Input handshake: accept when in_valid && in_ready on a posedge; output handshake k: out_valid[k] && out_ready[k].
REQ-016 Each output k has a one-entry slot with two states, EMPTY and FULL; out_valid[k] = (state k == FULL).
REQ-017 in_ready = (slot[in_sel] EMPTY) || out_ready[in_sel]; combinational, does not depend on in_valid.
REQ-018 EMPTY->FULL on accept with in_sel==k; data latched into outk_data.
REQ-019 FULL->EMPTY on output handshake k with no accept targeting k the same cycle.
REQ-020 FULL stays FULL with outk_data replaced by in_data when output handshake k and accept to k occur in the same cycle (full throughput, 1 beat/cycle per port).
REQ-021 Latency: beat accepted at edge N is visible on outk_data/out_valid[k] from edge N until consumed; min in-to-out = 1 cycle.
REQ-022 outk_data SHALL hold stable while out_valid[k]=1 and out_ready[k]=0; out_valid[k] never drops without a handshake.
REQ-023 Outputs are independent: a stalled sink blocks only beats selecting it; beats to other outputs may be accepted and delivered in any relative order.
REQ-024 At most one accept per cycle; output handshakes on all four ports may occur in the same cycle.
REQ-025 cntk increments by 1 on each output handshake k, wraps modulo 2^CWIDTH (all-ones -> 0).
REQ-026 in_sel and in_data are don't-care when in_valid=0; no state change from them.
REQ-027 outk_data contents when out_valid[k]=0 are don't-care but SHALL be deterministic after reset (zero until first write).

Reset
REQ-028 While rst=1 at a posedge: all slots EMPTY, out_valid=4'b0000, out*_data=0, cnt*=0, busy=0.
REQ-029 in_ready SHALL be 0 while rst is asserted; no accept or handshake is counted in a reset cycle.
REQ-030 Reset mid-operation discards all buffered beats; first accept after rst deasserts behaves as from power-up.

Verification
REQ-031 Reset then in_valid=1, in_sel=2, in_data=0xDEADBEEF, out_ready=4'b1111 -> next cycle out_valid=4'b0100, out2_data=0xDEADBEEF; following edge cnt2=1, out_valid=0.
REQ-032 out_ready[1]=0, send two beats to sel=1 (0x11, 0x22) -> first accepted, in_ready=0 for second; out1_data holds 0x11; raise out_ready[1] -> 0x22 accepted same edge 0x11 consumed, cnt1=1, then 2.
REQ-033 Stall port 0 full, stream beats to sel=3 with out_ready[3]=1 every cycle -> in_ready=1 every cycle, one beat/cycle on out3, port 0 unchanged.
REQ-034 CWIDTH=8, deliver 257 beats to port 0 -> cnt0=1 (wrap), no other counter changes.
REQ-035 Fill all four slots (out_ready=0), assert rst one cycle -> out_valid=0, cnt*=0, out*_data=0, busy=0; beat after reset delivered normally.
REQ-036 Random valid/ready/sel for 10k cycles with scoreboard per port -> per-port order preserved, no loss/duplication, data stable under stall.
